// File: rtl/matrix_operand_loader.sv
// matrix_operand_loader: streams operands row-major into the A then B stores of the matrix multiplier and starts it
//   clock, reset             : rising-edge clock, synchronous active-high reset
//   load_start               : one-cycle load request, honoured only in IDLE
//   in_valid/in_ready/in_data: operand element stream
//   a_wr_*                   : A store write port (row i, column k)
//   b_wr_*                   : B store write port (row k, column j)
//   mm_start/mm_done         : multiplier start pulse / completion pulse
//   busy/done                : not-idle flag / one-cycle load-complete pulse
module matrix_operand_loader #(
    parameter int DATA_WIDTH             = 8,
    parameter int FIRST_MATRIX_ROW_SIZE  = 20,
    parameter int MATRIX_SIZE            = 10,
    parameter int SECOND_MATRIX_COL_SIZE = 30,
    parameter int ROW_W = $clog2(FIRST_MATRIX_ROW_SIZE > MATRIX_SIZE ? FIRST_MATRIX_ROW_SIZE : MATRIX_SIZE),
    parameter int COL_W = $clog2(MATRIX_SIZE > SECOND_MATRIX_COL_SIZE ? MATRIX_SIZE : SECOND_MATRIX_COL_SIZE)
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  load_start,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  in_ready,
    output logic                  a_wr_en,
    output logic [ROW_W-1:0]      a_wr_row,
    output logic [COL_W-1:0]      a_wr_col,
    output logic [DATA_WIDTH-1:0] a_wr_data,
    output logic                  b_wr_en,
    output logic [ROW_W-1:0]      b_wr_row,
    output logic [COL_W-1:0]      b_wr_col,
    output logic [DATA_WIDTH-1:0] b_wr_data,
    output logic                  mm_start,
    input  logic                  mm_done,
    output logic                  busy,
    output logic                  done
);
    typedef enum logic [2:0] {IDLE, LOAD_A, LOAD_B, FLUSH, START, WAIT} state_e;

    localparam logic [ROW_W-1:0] A_ROW_LAST = ROW_W'(FIRST_MATRIX_ROW_SIZE - 1);
    localparam logic [COL_W-1:0] A_COL_LAST = COL_W'(MATRIX_SIZE - 1);
    localparam logic [ROW_W-1:0] B_ROW_LAST = ROW_W'(MATRIX_SIZE - 1);
    localparam logic [COL_W-1:0] B_COL_LAST = COL_W'(SECOND_MATRIX_COL_SIZE - 1);

    state_e                state_q, state_d;
    logic [ROW_W-1:0]      row_q, row_d;
    logic [COL_W-1:0]      col_q, col_d;
    logic                  a_en_q, a_en_d, b_en_q, b_en_d, done_q, done_d;
    logic [ROW_W-1:0]      a_row_q, a_row_d, b_row_q, b_row_d;
    logic [COL_W-1:0]      a_col_q, a_col_d, b_col_q, b_col_d;
    logic [DATA_WIDTH-1:0] a_data_q, a_data_d, b_data_q, b_data_d;
    logic                  beat, in_a, col_last, row_last;

    assign in_ready = (state_q == LOAD_A) || (state_q == LOAD_B);
    assign beat     = in_valid && in_ready;
    assign in_a     = state_q == LOAD_A;
    assign col_last = in_a ? (col_q == A_COL_LAST) : (col_q == B_COL_LAST);
    assign row_last = in_a ? (row_q == A_ROW_LAST) : (row_q == B_ROW_LAST);

    assign a_wr_en   = a_en_q;
    assign a_wr_row  = a_row_q;
    assign a_wr_col  = a_col_q;
    assign a_wr_data = a_data_q;
    assign b_wr_en   = b_en_q;
    assign b_wr_row  = b_row_q;
    assign b_wr_col  = b_col_q;
    assign b_wr_data = b_data_q;
    assign mm_start  = state_q == START;
    assign busy      = state_q != IDLE;
    assign done      = done_q;

    always_comb begin
        state_d  = state_q;
        row_d    = row_q;
        col_d    = col_q;
        a_en_d   = 1'b0;
        b_en_d   = 1'b0;
        done_d   = 1'b0;
        a_row_d  = a_row_q;
        a_col_d  = a_col_q;
        a_data_d = a_data_q;
        b_row_d  = b_row_q;
        b_col_d  = b_col_q;
        b_data_d = b_data_q;
        case (state_q)
            IDLE:  state_d = load_start ? LOAD_A : IDLE;
            LOAD_A, LOAD_B: begin
                if (beat) begin
                    // index/data registers only move on a beat so they hold between writes
                    if (in_a) begin
                        a_en_d   = 1'b1;
                        a_row_d  = row_q;
                        a_col_d  = col_q;
                        a_data_d = in_data;
                    end else begin
                        b_en_d   = 1'b1;
                        b_row_d  = row_q;
                        b_col_d  = col_q;
                        b_data_d = in_data;
                    end
                    col_d = col_last ? '0 : col_q + COL_W'(1);
                    if (col_last) begin
                        row_d = row_last ? '0 : row_q + ROW_W'(1);
                        if (row_last) state_d = in_a ? LOAD_B : FLUSH;
                    end
                end
            end
            // the final B write is on the port during FLUSH, so START follows it by one cycle
            FLUSH: state_d = START;
            START: state_d = WAIT;
            WAIT: begin
                state_d = mm_done ? IDLE : WAIT;
                done_d  = mm_done;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= IDLE;
            row_q    <= '0;
            col_q    <= '0;
            a_en_q   <= 1'b0;
            b_en_q   <= 1'b0;
            done_q   <= 1'b0;
            a_row_q  <= '0;
            a_col_q  <= '0;
            a_data_q <= '0;
            b_row_q  <= '0;
            b_col_q  <= '0;
            b_data_q <= '0;
        end else begin
            state_q  <= state_d;
            row_q    <= row_d;
            col_q    <= col_d;
            a_en_q   <= a_en_d;
            b_en_q   <= b_en_d;
            done_q   <= done_d;
            a_row_q  <= a_row_d;
            a_col_q  <= a_col_d;
            a_data_q <= a_data_d;
            b_row_q  <= b_row_d;
            b_col_q  <= b_col_d;
            b_data_q <= b_data_d;
        end
    end
endmodule

// File: tb/tb_matrix_operand_loader.sv
// tb_matrix_operand_loader: directed self-checking bench for matrix_operand_loader
module tb_matrix_operand_loader;
    localparam int R  = 20;
    localparam int M  = 10;
    localparam int C  = 30;
    localparam int RW = $clog2(R > M ? R : M);
    localparam int CW = $clog2(M > C ? M : C);

    logic          clock = 1'b0;
    logic          reset, load_start, in_valid, mm_done;
    logic [7:0]    in_data;
    logic          in_ready, a_wr_en, b_wr_en, mm_start, busy, done;
    logic [RW-1:0] a_wr_row, b_wr_row;
    logic [CW-1:0] a_wr_col, b_wr_col;
    logic [7:0]    a_wr_data, b_wr_data;

    matrix_operand_loader #(
        .DATA_WIDTH(8), .FIRST_MATRIX_ROW_SIZE(R), .MATRIX_SIZE(M), .SECOND_MATRIX_COL_SIZE(C)
    ) dut (
        .clock(clock), .reset(reset), .load_start(load_start),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .a_wr_en(a_wr_en), .a_wr_row(a_wr_row), .a_wr_col(a_wr_col), .a_wr_data(a_wr_data),
        .b_wr_en(b_wr_en), .b_wr_row(b_wr_row), .b_wr_col(b_wr_col), .b_wr_data(b_wr_data),
        .mm_start(mm_start), .mm_done(mm_done), .busy(busy), .done(done)
    );

    always #5 clock = ~clock;

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0, a_cnt = 0, b_cnt = 0, start_cnt = 0, done_cnt = 0, viol = 0;
    int last_b_cyc = 0, start_cyc = 0;
    bit prev_acc = 1'b0;
    int a_mem [R][M];
    int b_mem [M][C];

    task automatic check(input string tag, input int got, input int exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // write capture and per-cycle strobe rules: a strobe appears exactly one cycle after each accepted beat
    always @(negedge clock) begin
        cyc++;
        if (a_wr_en) begin
            if (int'(a_wr_row) < R && int'(a_wr_col) < M) a_mem[a_wr_row][a_wr_col] = int'(a_wr_data);
            a_cnt++;
        end
        if (b_wr_en) begin
            if (int'(b_wr_row) < M && int'(b_wr_col) < C) b_mem[b_wr_row][b_wr_col] = int'(b_wr_data);
            b_cnt++;
            last_b_cyc = cyc;
        end
        if (a_wr_en && b_wr_en) viol++;
        if ((a_wr_en || b_wr_en) != prev_acc) viol++;
        if (mm_start) begin
            start_cnt++;
            start_cyc = cyc;
        end
        if (done) done_cnt++;
        prev_acc = in_valid && in_ready && !reset;
    end

    task automatic clear();
        a_cnt = 0; b_cnt = 0; start_cnt = 0; done_cnt = 0;
        start_cyc = 0; last_b_cyc = 0;
        foreach (a_mem[i, k]) a_mem[i][k] = -1;
        foreach (b_mem[k, j]) b_mem[k][j] = -1;
    endtask

    task automatic start_load();
        @(posedge clock); #1 load_start = 1'b1;
        @(posedge clock); #1 load_start = 1'b0;
    endtask

    // gap toggles in_valid 1,0,1,0; spur injects mm_done in LOAD_A and load_start in LOAD_B
    task automatic stream(input int n, input bit gap, input bit spur);
        int k = 0;
        int cycles = 0;
        bit tog = 1'b1;
        bit acc;
        while (k < n && cycles < 5000) begin
            in_valid   = gap ? tog : 1'b1;
            in_data    = k[7:0];
            mm_done    = spur && k == 50;
            load_start = spur && k == 250;
            @(negedge clock);
            acc = in_valid && in_ready;
            @(posedge clock); #1;
            if (acc) k++;
            tog = !tog;
            cycles++;
        end
        in_valid = 1'b0; mm_done = 1'b0; load_start = 1'b0;
        check("stream_beats", k, n);
    endtask

    task automatic finish_load(input bit spur, input bit b2b);
        int n = 0;
        @(negedge clock);
        while (!mm_start && n < 20) begin
            @(negedge clock);
            n++;
        end
        check("mm_start_seen", int'(mm_start), 1);
        for (int i = 0; i < 20; i++) begin
            @(posedge clock); #1;
            load_start = spur && i == 10;
            mm_done    = i == 19;
        end
        @(posedge clock); #1 mm_done = 1'b0; load_start = b2b;
        @(negedge clock);
        check("done_pulse", int'(done), 1);
        check("busy_after_done", int'(busy), 0);
        @(posedge clock); #1 load_start = 1'b0;
        @(negedge clock);
        check("done_one_cycle", int'(done), 0);
        check("busy_next", int'(busy), int'(b2b));
        @(posedge clock); #1;
    endtask

    task automatic verify(input string tag);
        int errs = 0;
        for (int i = 0; i < R; i++)
            for (int k = 0; k < M; k++)
                if (a_mem[i][k] != (i * M + k) % 256) errs++;
        for (int k = 0; k < M; k++)
            for (int j = 0; j < C; j++)
                if (b_mem[k][j] != (R * M + k * C + j) % 256) errs++;
        $display("load %s checked", tag);
        check("a_writes", a_cnt, 200);
        check("b_writes", b_cnt, 300);
        check("a_3_7", a_mem[3][7], 37);
        check("b_2_5", b_mem[2][5], 9);
        check("contents", errs, 0);
        check("mm_start_cnt", start_cnt, 1);
        check("start_after_last_b", start_cyc - last_b_cyc, 1);
        check("done_cnt", done_cnt, 1);
        check("strobe_rules", viol, 0);
    endtask

    initial begin
        int bad;
        reset = 1'b1; load_start = 1'b0; in_valid = 1'b0; mm_done = 1'b0; in_data = '0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        check("rst_in_ready", int'(in_ready), 0);
        check("rst_a_wr_en", int'(a_wr_en), 0);
        check("rst_b_wr_en", int'(b_wr_en), 0);
        check("rst_mm_start", int'(mm_start), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_idx", int'({a_wr_row, a_wr_col, b_wr_row, b_wr_col}), 0);
        check("rst_data", int'({a_wr_data, b_wr_data}), 0);
        @(posedge clock); #1 reset = 1'b0;

        clear(); start_load(); stream(500, 1'b0, 1'b0); finish_load(1'b0, 1'b0); verify("nominal");

        clear(); start_load(); stream(500, 1'b1, 1'b0); finish_load(1'b0, 1'b0); verify("gaps");

        @(posedge clock); #1 mm_done = 1'b1;
        @(posedge clock); #1 mm_done = 1'b0;
        @(negedge clock);
        check("idle_mm_done_busy", int'(busy), 0);
        check("idle_mm_done_done", int'(done), 0);
        @(posedge clock); #1;
        clear(); start_load(); stream(500, 1'b0, 1'b1); finish_load(1'b1, 1'b0); verify("spurious");

        clear(); start_load(); stream(150, 1'b0, 1'b0);
        in_valid = 1'b1; in_data = 8'd150; reset = 1'b1;
        @(posedge clock); #1 reset = 1'b0; in_valid = 1'b0;
        @(negedge clock);
        check("abort_a_wr_en", int'(a_wr_en), 0);
        check("abort_in_ready", int'(in_ready), 0);
        check("abort_busy", int'(busy), 0);
        check("abort_a_idx", int'({a_wr_row, a_wr_col}), 0);
        check("abort_a_data", int'(a_wr_data), 0);
        repeat (5) @(negedge clock);
        check("abort_a_cnt", a_cnt, 150);
        check("abort_no_start", start_cnt, 0);
        check("abort_no_done", done_cnt, 0);
        @(posedge clock); #1;
        clear(); start_load(); stream(500, 1'b0, 1'b0); finish_load(1'b0, 1'b0); verify("after_reset");

        clear(); bad = 0; in_valid = 1'b1;
        repeat (10) begin
            @(negedge clock);
            if (in_ready || busy) bad++;
        end
        @(posedge clock); #1 in_valid = 1'b0;
        check("idle_reject", bad, 0);
        check("idle_writes", a_cnt + b_cnt, 0);

        clear(); start_load(); stream(500, 1'b0, 1'b0); finish_load(1'b0, 1'b1); verify("b2b_first");
        clear(); stream(500, 1'b0, 1'b0); finish_load(1'b0, 1'b0); verify("b2b_second");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/matrix_operand_loader.md
Name: matrix_operand_loader

Overview:
Upstream feeder for the tiled matrix multiplier. Accepts a single valid/ready stream of operand elements and writes them, row-major, into the multiplier's A store (FIRST_MATRIX_ROW_SIZE x MATRIX_SIZE) and then its B store (MATRIX_SIZE x SECOND_MATRIX_COL_SIZE). Once both stores are fully written, it pulses the multiplier start and waits for the multiplier's completion before accepting the next load.

Parameters:
DATA_WIDTH, 8, element width in bits
FIRST_MATRIX_ROW_SIZE, 20, rows of A
MATRIX_SIZE, 10, columns of A and rows of B (the shared dimension)
SECOND_MATRIX_COL_SIZE, 30, columns of B
ROW_W, $clog2 of max(FIRST_MATRIX_ROW_SIZE, MATRIX_SIZE), derived; width of write row index
COL_W, $clog2 of max(MATRIX_SIZE, SECOND_MATRIX_COL_SIZE), derived; width of write column index

Ports:
clock  in  1  system clock; all logic on the rising edge
reset  in  1  synchronous, active-high reset
load_start  in  1  one-cycle request to begin a load; sampled only in IDLE
in_valid  in  1  operand stream valid
in_data  in  DATA_WIDTH  operand element
in_ready  out  1  operand stream ready
a_wr_en  out  1  A store write strobe
a_wr_row  out  ROW_W  A row index i
a_wr_col  out  COL_W  A column index k
a_wr_data  out  DATA_WIDTH  A element
b_wr_en  out  1  B store write strobe
b_wr_row  out  ROW_W  B row index k
b_wr_col  out  COL_W  B column index j
b_wr_data  out  DATA_WIDTH  B element
mm_start  out  1  one-cycle start pulse to the multiplier
mm_done  in  1  one-cycle completion pulse from the multiplier
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse when the multiplier completes

Behaviour:
- Reset: state IDLE, all counters 0. in_ready, a_wr_en, b_wr_en, mm_start, busy and done are 0. Index and data outputs are 0.
- States: IDLE, LOAD_A, LOAD_B, FLUSH, START, WAIT.
- IDLE: in_ready=0. load_start=1 moves to LOAD_A on the next edge. in_valid is ignored.
- LOAD_A: in_ready=1. A beat is accepted when in_valid and in_ready are both 1.
  - Each beat registers a write one cycle later: a_wr_en=1, row=r, col=c, data=in_data.
  - The counters advance c first (0..MATRIX_SIZE-1), then r (0..FIRST_MATRIX_ROW_SIZE-1).
  - The beat at r=ROWS-1, c=MATRIX_SIZE-1 clears the counters and moves to LOAD_B.
- LOAD_B: same mechanism on the B port.
  - Column index j runs 0..SECOND_MATRIX_COL_SIZE-1; row index k runs 0..MATRIX_SIZE-1.
  - The final beat moves to FLUSH, and in_ready drops to 0 in the following cycle.
- A idle in_valid=0 cycle produces no write and does not advance any counter. Stalls of any length are legal.
- FLUSH: a single cycle during which the last B write strobe is driven. Then go to START.
- START: mm_start=1 for exactly one cycle, then go to WAIT. The last B write therefore precedes mm_start by exactly one cycle.
- WAIT: the block waits for mm_done=1. On that edge it goes to IDLE and drives done=1 for one cycle.
- mm_done seen outside WAIT is ignored.
- load_start seen outside IDLE is ignored.
- load_start and mm_done asserted in the same cycle: this can only occur in WAIT, so load_start is ignored.
- There is never more than one write strobe per cycle, and a_wr_en and b_wr_en are never high together.
- Total accepted beats per load = R*M + M*C (defaults: 200 + 300 = 500).
- Reset asserted mid-load: returns to IDLE on that edge. No further write strobes occur, including any pending one. Counters clear. No mm_start and no done are produced.
- Index outputs hold their last value when the write strobes are low.

Test Plan:
- Nominal load: reset for 2 cycles, pulse load_start, stream 500 beats with value = beat index mod 256, in_valid held high, then pulse mm_done 20 cycles after mm_start. Required:
  - 200 A writes; A[3][7] = 37.
  - 300 B writes; B[2][5] = (200 + 65) mod 256 = 9.
  - Exactly one mm_start, one cycle after the final b_wr_en.
  - done one cycle after mm_done; busy low afterwards.
- Backpressure/gaps: repeat the nominal load with in_valid toggling 1,0,1,0. Required: identical write contents and a write count of 500; no strobe in any cycle following an in_valid=0 cycle.
- Spurious controls: pulse mm_done in IDLE and in LOAD_A, and pulse load_start during LOAD_B and WAIT. Required: no state change, no done, no restarted count; the A-to-B boundary stays at beat 200.
- Reset mid-operation: assert reset at beat 150 of A for 1 cycle. Required:
  - All outputs return to 0 on that edge, with no write following it and no mm_start.
  - A subsequent full load behaves as the nominal load.
- Idle rejection: drive in_valid=1 for 10 cycles in IDLE. Required: in_ready=0, no write strobes, busy=0.
- Back-to-back loads: pulse load_start in the same cycle done is asserted. Required: LOAD_A is entered on the next edge and a second correct 500-beat load completes.
